// File: rtl/weight_fetch_unit.sv
// weight_fetch_unit: streams num_tiles*MUL_SIZE weight rows from memory into a credit-protected FIFO.
// Define WEIGHT_STALL_CNT_EN to add the stall_cycles_o counter output.
module weight_fetch_unit #(
    parameter int MUL_SIZE = 8,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 16,
    parameter int TILE_W   = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       instruction_i,
    input  logic [ADDR_W-1:0]          base_addr_i,
    input  logic [TILE_W-1:0]          num_tiles_i,
    output logic                       mem_rd_en_o,
    output logic [ADDR_W-1:0]          mem_rd_addr_o,
    input  logic [MUL_SIZE*DATA_W-1:0] mem_rd_data_i,
    input  logic                       load_weights_i,
    output logic                       weight_fifo_valid_o,
    output logic [MUL_SIZE*DATA_W-1:0] weight_row_o,
    output logic                       busy_o,
    output logic                       done_o
`ifdef WEIGHT_STALL_CNT_EN
    ,
    output logic [31:0]                stall_cycles_o
`endif
);
    localparam int DEPTH = 2 * MUL_SIZE;
    localparam int PW    = $clog2(DEPTH);
    localparam int SW    = $clog2(MUL_SIZE);
    localparam int CW    = TILE_W + SW;
    localparam int RW    = MUL_SIZE * DATA_W;
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     rd_cnt_q, rd_cnt_d, pop_cnt_q, pop_cnt_d, total;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       occ_q;
    logic              in_flight_q, done_q, done_d, accept, push, pop;
    logic [RW-1:0]     fifo_q [DEPTH];

    assign accept              = instruction_i && (state_q == IDLE);
    assign total               = CW'(num_tiles_i) << SW;
    assign push                = in_flight_q;
    assign weight_fifo_valid_o = (occ_q != '0);
    assign pop                 = weight_fifo_valid_o && load_weights_i;
    // A read may only issue if its row is guaranteed a free FIFO slot on arrival.
    assign mem_rd_en_o         = (state_q == FETCH) && (rd_cnt_q != '0) &&
                                 (occ_q + (PW+1)'(in_flight_q) < DEPTH_C);
    assign mem_rd_addr_o       = addr_q;
    assign weight_row_o        = weight_fifo_valid_o ? fifo_q[rd_ptr_q] : '0;
    assign busy_o              = (state_q != IDLE);
    assign done_o              = done_q;

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        addr_d    = addr_q;
        pop_cnt_d = pop ? pop_cnt_q - CW'(1) : pop_cnt_q;
        done_d    = 1'b0;
        if (accept) begin
            addr_d    = base_addr_i;
            rd_cnt_d  = total;
            pop_cnt_d = total;
            state_d   = (num_tiles_i == '0) ? IDLE : FETCH;
            done_d    = (num_tiles_i == '0);
        end
        if (mem_rd_en_o) begin
            rd_cnt_d = rd_cnt_q - CW'(1);
            addr_d   = addr_q + ADDR_W'(1);
            state_d  = (rd_cnt_q == CW'(1)) ? DRAIN : FETCH;
        end
        if (state_q == DRAIN && pop_cnt_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            rd_cnt_q    <= '0;
            pop_cnt_q   <= '0;
            addr_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            in_flight_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            pop_cnt_q   <= pop_cnt_d;
            addr_q      <= addr_d;
            wr_ptr_q    <= wr_ptr_q + PW'(push);
            rd_ptr_q    <= rd_ptr_q + PW'(pop);
            occ_q       <= occ_q + (PW+1)'(push) - (PW+1)'(pop);
            in_flight_q <= mem_rd_en_o;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= mem_rd_data_i;
    end

`ifdef WEIGHT_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = accept ? '0 :
                  (load_weights_i && !weight_fifo_valid_o && !(&stall_q)) ? stall_q + 32'd1 : stall_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) stall_q <= '0;
        else stall_q <= stall_d;
    end

    assign stall_cycles_o = stall_q;
`endif
endmodule
